// File: rtl/if_prefetch_queue.sv
// -----------------------------------------------------------------------------
// if_prefetch_queue
//
// Instruction-fetch front end. A small PC sequencer issues one word-aligned
// fetch at a time to a variable-latency instruction memory and stores each
// returned {pc, instr} pair in a DEPTH-entry prefetch FIFO that the ID stage
// drains. A redirect from EX flushes the FIFO, retargets the fetch PC and
// discards whatever fetch is still in flight.
//
// Handshakes (valid/ready): a transfer happens on a rising clk edge where
// both valid and ready are high. A producer that raises valid keeps valid
// and its payload stable until that transfer happens; ready may change
// freely and has no effect while valid is low.
//
// Ports
//   clk, rstn        clock, asynchronous active-low reset
//   imem_req_valid   fetch request valid (held until imem_req_ready)
//   imem_req_ready   memory accepts the request
//   imem_req_addr    fetch address, word aligned
//   imem_rsp_valid   response valid, in order, one per accepted request
//   imem_rsp_data    instruction word returned by memory
//   redirect_valid   EX-stage taken branch/jump
//   redirect_pc      redirect target (low two bits ignored)
//   out_valid        FIFO head valid
//   out_ready        ID stage consumes the head
//   out_instr        head instruction
//   out_pc           head PC
//   out_pcnext       head PC + 4 (wraps)
//   occupancy        number of valid FIFO entries
// -----------------------------------------------------------------------------
module if_prefetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rstn,
    output logic                       imem_req_valid,
    input  logic                       imem_req_ready,
    output logic [XLEN-1:0]            imem_req_addr,
    input  logic                       imem_rsp_valid,
    input  logic [31:0]                imem_rsp_data,
    input  logic                       redirect_valid,
    input  logic [XLEN-1:0]            redirect_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_instr,
    output logic [XLEN-1:0]            out_pc,
    output logic [XLEN-1:0]            out_pcnext,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    // DROP_REQ / DROP: a request issued before a redirect is still owed a
    // response by memory; that response must be swallowed.
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_REQ      = 3'd1,
        S_WAIT     = 3'd2,
        S_DROP_REQ = 3'd3,
        S_DROP     = 3'd4
    } state_t;

    state_t state, state_next;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] req_pc;          // address of the request being presented / in flight
    logic [XLEN-1:0] redirect_target;
    logic            req_fire;
    logic            push;
    logic            pop;

    logic [XLEN-1:0] mem_pc    [DEPTH];
    logic [31:0]     mem_instr [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;

    assign redirect_target = redirect_pc & ~XLEN'(3);
    assign req_fire        = imem_req_valid && imem_req_ready;
    // A redirect in the same cycle kills both the push and the pop.
    assign push            = (state == S_WAIT) && imem_rsp_valid && !redirect_valid;
    assign pop             = out_valid && out_ready && !redirect_valid;

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        imem_req_valid = 1'b0;
        imem_req_addr  = fetch_pc;
        case (state)
            S_IDLE: begin
                if (!redirect_valid && (count < CNT_W'(DEPTH))) begin
                    state_next = S_REQ;
                end
            end
            S_REQ: begin
                imem_req_valid = 1'b1;
                if (redirect_valid) begin
                    state_next = req_fire ? S_DROP : S_DROP_REQ;
                end else if (req_fire) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    state_next = S_IDLE;
                end else if (redirect_valid) begin
                    state_next = S_DROP;
                end
            end
            S_DROP_REQ: begin
                // fetch_pc already holds the redirect target, so present the
                // stale address captured while in S_REQ.
                imem_req_valid = 1'b1;
                imem_req_addr  = req_pc;
                if (req_fire) begin
                    state_next = S_DROP;
                end
            end
            S_DROP: begin
                if (imem_rsp_valid) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Fetch PC and in-flight request PC
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
        end else begin
            if (redirect_valid) begin
                fetch_pc <= redirect_target;
            end else if ((state == S_REQ) && req_fire) begin
                fetch_pc <= fetch_pc + XLEN'(4);
            end
            // While presenting a request, remember its address so WAIT can
            // tag the response and DROP_REQ can keep presenting it.
            if (state == S_REQ) begin
                req_pc <= fetch_pc;
            end
        end
    end

    // ------------------------------------------------------------------
    // Prefetch FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wr_ptr]    <= req_pc;
            mem_instr[wr_ptr] <= imem_rsp_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (redirect_valid) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Head outputs read 0 when the FIFO is empty so nothing stale leaks out.
    assign out_valid  = (count != '0);
    assign occupancy  = count;
    assign out_instr  = out_valid ? mem_instr[rd_ptr] : 32'd0;
    assign out_pc     = out_valid ? mem_pc[rd_ptr] : '0;
    assign out_pcnext = out_valid ? (mem_pc[rd_ptr] + XLEN'(4)) : '0;

    // Responses are only legal while a fetch is outstanding.
    rsp_only_when_outstanding: assert property (
        @(posedge clk) disable iff (!rstn)
        imem_rsp_valid |-> ((state == S_WAIT) || (state == S_DROP))
    );

endmodule

// File: tb/tb_if_prefetch_queue.sv
// -----------------------------------------------------------------------------
// tb_if_prefetch_queue
//
// Drives if_prefetch_queue with a behavioural instruction memory and ID-stage
// consumer. A reference model tracks, per cycle, which fetches are still
// "live" (no redirect since they were first presented) and holds the {pc,
// instr} pairs the ID stage must receive in order.
// -----------------------------------------------------------------------------
module tb_if_prefetch_queue;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam int W     = 64;

    logic            clk;
    logic            rstn;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_instr;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_pcnext;
    logic [2:0]      occupancy;

    if_prefetch_queue #(
        .XLEN    (XLEN),
        .DEPTH   (DEPTH),
        .RESET_PC(32'h0)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .out_pcnext    (out_pcnext),
        .occupancy     (occupancy)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model / scoreboard state ----------------
    int checks = 0;
    int errors = 0;

    logic [W-1:0]  exp_q[$];     // {pc, instr} the ID stage must see next
    int            gen;          // bumps on every redirect or reset
    bit            req_seen;
    int            req_tag;
    logic [31:0]   req_addr_held;
    logic [31:0]   exp_addr;     // address the next fresh request must use
    bit            mem_busy;
    int            mem_cnt;
    int            out_tag;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_data;
    int            ready_pct;
    int            mem_lat;
    int            push_cnt;
    int            acc_cnt;
    logic [31:0]   req_log[$];
    logic [31:0]   acc_log[$];
    logic [31:0]   pop_log[$];
    logic [31:0]   pcnext_log[$];

    task automatic model_reset();
        exp_q.delete();
        gen++;
        req_seen = 1'b0;
        mem_busy = 1'b0;
        mem_cnt  = 0;
        exp_addr = 32'h0;
        push_cnt = 0;
        acc_cnt  = 0;
        req_log.delete();
        acc_log.delete();
        pop_log.delete();
        pcnext_log.delete();
    endtask

    task automatic do_reset();
        rstn           = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    // One clock cycle: memory/consumer drive, model update, post-edge check.
    // Called at a falling edge; test code sets out_ready / redirect first.
    task automatic step();
        logic [W-1:0]  e;
        logic [31:0]   nxt;
        imem_req_ready = ($urandom_range(99) < ready_pct);
        if (mem_busy && mem_cnt == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_data;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        #1;
        if (imem_req_valid) begin
            checks++;
            if (mem_busy) begin
                errors++;
                $display("FAIL one_outstanding: request valid while a fetch is in flight");
            end
            checks++;
            if (!req_seen) begin
                req_seen      = 1'b1;
                req_tag       = gen;
                req_addr_held = imem_req_addr;
                req_log.push_back(imem_req_addr);
                if (imem_req_addr !== exp_addr) begin
                    errors++;
                    $display("FAIL req_addr: got %h expected %h", imem_req_addr, exp_addr);
                end
            end else if (imem_req_addr !== req_addr_held) begin
                errors++;
                $display("FAIL req_hold: got %h expected %h", imem_req_addr, req_addr_held);
            end
        end
        if (out_valid && out_ready && !redirect_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_empty: popped pc %h with nothing expected", out_pc);
            end else begin
                e   = exp_q.pop_front();
                nxt = e[63:32] + 32'd4;
                pop_log.push_back(out_pc);
                pcnext_log.push_back(out_pcnext);
                if ({out_pc, out_instr} !== e || out_pcnext !== nxt) begin
                    errors++;
                    $display("FAIL pop_data: got pc %h instr %h next %h expected pc %h instr %h next %h",
                             out_pc, out_instr, out_pcnext, e[63:32], e[31:0], nxt);
                end
            end
        end
        if (imem_rsp_valid) begin
            if (out_tag == gen && !redirect_valid) begin
                exp_q.push_back({mem_addr, mem_data});
                push_cnt++;
            end
            mem_busy = 1'b0;
        end else if (mem_busy) begin
            mem_cnt--;
        end
        if (imem_req_valid && imem_req_ready) begin
            mem_busy = 1'b1;
            mem_cnt  = mem_lat - 1;
            mem_addr = req_addr_held;
            mem_data = $urandom;
            out_tag  = req_tag;
            req_seen = 1'b0;
            acc_cnt++;
            acc_log.push_back(req_addr_held);
            if (req_tag == gen && !redirect_valid) exp_addr = exp_addr + 32'd4;
        end
        if (redirect_valid) begin
            exp_q.delete();
            gen++;
            exp_addr = redirect_pc & ~32'h3;
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() > DEPTH || occupancy !== 3'(exp_q.size()) ||
            out_valid !== (exp_q.size() != 0)) begin
            errors++;
            $display("FAIL occupancy: got %0d valid %b expected %0d", occupancy, out_valid, exp_q.size());
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        checks++;
        if (imem_req_valid !== 1'b0 || imem_req_addr !== 32'h0 || out_valid !== 1'b0 ||
            out_instr !== 32'h0 || out_pc !== 32'h0 || out_pcnext !== 32'h0 || occupancy !== 3'd0) begin
            errors++;
            $display("FAIL reset_outputs: vld %b addr %h ov %b instr %h pc %h next %h occ %0d expected all 0",
                     imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc, out_pcnext, occupancy);
        end
    endtask

    task automatic test_stream();
        do_reset();
        ready_pct = 100; mem_lat = 1; out_ready = 1'b1;
        repeat (30) step();
        checks++;
        if (push_cnt != 10) begin
            errors++;
            $display("FAIL stream_rate: got %0d fetches in 30 cycles expected 10", push_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (req_log.size() <= i || req_log[i] !== 32'(4 * i)) begin
                errors++;
                $display("FAIL stream_addr%0d: expected %h", i, 32'(4 * i));
            end
            checks++;
            if (pop_log.size() <= i || pop_log[i] !== 32'(4 * i) || pcnext_log[i] !== 32'(4 * i + 4)) begin
                errors++;
                $display("FAIL stream_out%0d: expected pc %h next %h", i, 32'(4 * i), 32'(4 * i + 4));
            end
        end
    endtask

    task automatic test_full();
        do_reset();
        ready_pct = 100; mem_lat = 1; out_ready = 1'b0;
        repeat (40) step();
        checks++;
        if (acc_cnt != DEPTH || occupancy !== 3'(DEPTH) || imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL full_stop: accepted %0d occ %0d vld %b expected 4 4 0", acc_cnt, occupancy, imem_req_valid);
        end
        out_ready = 1'b1;
        repeat (12) step();
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (pop_log.size() <= i || pop_log[i] !== 32'(4 * i)) begin
                errors++;
                $display("FAIL full_drain%0d: expected pc %h", i, 32'(4 * i));
            end
        end
    endtask

    task automatic test_redirect_wait();
        do_reset();
        ready_pct = 100; mem_lat = 3; out_ready = 1'b1;
        for (int i = 0; i < 20 && !mem_busy; i++) step();
        checks++;
        if (!mem_busy) begin
            errors++;
            $display("FAIL rw_timeout: no request accepted");
        end
        redirect_valid = 1'b1; redirect_pc = 32'h103;
        step();
        redirect_valid = 1'b0;
        checks++;
        if (occupancy !== 3'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rw_flush: occ %0d valid %b expected 0 0", occupancy, out_valid);
        end
        req_log.delete(); pop_log.delete();
        repeat (15) step();
        checks++;
        if (req_log.size() < 1 || req_log[0] !== 32'h100) begin
            errors++;
            $display("FAIL rw_addr: expected first request 00000100");
        end
        checks++;
        if (pop_log.size() < 1 || pop_log[0] !== 32'h100) begin
            errors++;
            $display("FAIL rw_out: expected first out_pc 00000100");
        end
    endtask

    task automatic test_redirect_held();
        do_reset();
        ready_pct = 0; mem_lat = 1; out_ready = 1'b1;
        for (int i = 0; i < 10 && !imem_req_valid; i++) step();
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        step();
        redirect_valid = 1'b0;
        acc_log.delete(); pop_log.delete();
        repeat (3) step();
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
            errors++;
            $display("FAIL rh_hold: vld %b addr %h expected 1 00000000", imem_req_valid, imem_req_addr);
        end
        ready_pct = 100;
        repeat (12) step();
        checks++;
        if (acc_log.size() < 2 || acc_log[0] !== 32'h0 || acc_log[1] !== 32'h200) begin
            errors++;
            $display("FAIL rh_accept: expected accepted 00000000 then 00000200");
        end
        checks++;
        if (pop_log.size() < 1 || pop_log[0] !== 32'h200) begin
            errors++;
            $display("FAIL rh_out: expected first out_pc 00000200");
        end
    endtask

    task automatic test_redirect_pop_rsp();
        do_reset();
        ready_pct = 100; mem_lat = 1; out_ready = 1'b0;
        for (int i = 0; i < 30 && !(exp_q.size() >= 1 && mem_busy && mem_cnt == 0); i++) step();
        checks++;
        if (!(exp_q.size() >= 1 && mem_busy && mem_cnt == 0)) begin
            errors++;
            $display("FAIL rp_timeout: could not line up pop with response");
        end
        out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h300;
        step();
        redirect_valid = 1'b0;
        checks++;
        if (occupancy !== 3'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rp_flush: occ %0d valid %b expected 0 0", occupancy, out_valid);
        end
        pop_log.delete();
        repeat (10) step();
        checks++;
        if (pop_log.size() < 1 || pop_log[0] !== 32'h300) begin
            errors++;
            $display("FAIL rp_out: expected first out_pc 00000300");
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        ready_pct = 100; mem_lat = 3; out_ready = 1'b1;
        for (int i = 0; i < 20 && !mem_busy; i++) step();
        rstn = 1'b0;
        model_reset();
        imem_rsp_valid = 1'b1; imem_rsp_data = $urandom; imem_req_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (imem_req_valid !== 1'b0 || imem_req_addr !== 32'h0 || occupancy !== 3'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rm_during: vld %b addr %h occ %0d ov %b expected 0", imem_req_valid, imem_req_addr, occupancy, out_valid);
        end
        imem_rsp_valid = 1'b0;
        rstn = 1'b1;
        #1;
        checks++;
        if (imem_req_addr !== 32'h0 || occupancy !== 3'd0) begin
            errors++;
            $display("FAIL rm_release: addr %h occ %0d expected 0 0", imem_req_addr, occupancy);
        end
        repeat (15) step();
        checks++;
        if (req_log.size() < 1 || req_log[0] !== 32'h0 || pop_log.size() < 1 || pop_log[0] !== 32'h0) begin
            errors++;
            $display("FAIL rm_restart: expected fetch and output from 00000000");
        end
    endtask

    task automatic test_wrap();
        do_reset();
        ready_pct = 100; mem_lat = 1; out_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        step();
        redirect_valid = 1'b0;
        req_log.delete(); pop_log.delete(); pcnext_log.delete();
        repeat (12) step();
        checks++;
        if (req_log.size() < 2 || req_log[0] !== 32'hFFFF_FFFC || req_log[1] !== 32'h0) begin
            errors++;
            $display("FAIL wrap_addr: expected fffffffc then 00000000");
        end
        checks++;
        if (pop_log.size() < 1 || pop_log[0] !== 32'hFFFF_FFFC || pcnext_log[0] !== 32'h0) begin
            errors++;
            $display("FAIL wrap_out: expected pc fffffffc next 00000000");
        end
    endtask

    task automatic test_random();
        do_reset();
        ready_pct = 100; mem_lat = 1;
        for (int i = 0; i < 1500; i++) begin
            if (i % 100 == 0) begin
                ready_pct = $urandom_range(100, 30);
                mem_lat   = $urandom_range(4, 1);
            end
            out_ready      = ($urandom_range(99) < 60);
            redirect_valid = ($urandom_range(99) < 4);
            redirect_pc    = $urandom;
            step();
        end
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        repeat (20) step();
        checks++;
        if (push_cnt < 50) begin
            errors++;
            $display("FAIL random_progress: only %0d fetches delivered", push_cnt);
        end
    endtask

    initial begin
        rstn           = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        ready_pct      = 100;
        mem_lat        = 1;
        gen            = 0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_stream();
        test_full();
        test_redirect_wait();
        test_redirect_held();
        test_redirect_pop_rsp();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
